// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose:
//   Sequences the shared Mult and Div units and the Hi/Lo registers for the
//   multicycle CPU. One start/op request from the control unit is turned into:
//     1. a LOAD cycle for the selected unit,
//     2. a RUN phase that waits for that unit to finish,
//     3. a Hi/Lo write,
//     4. a done pulse.
//   A divide-by-zero or invalid divide ends in an err pulse instead. A RUN
//   phase that never completes is cut off after MAX_CYCLES cycles. An abort
//   cancels the operation without any done or err pulse.
//
// Parameters:
//   MAX_CYCLES : maximum RUN cycles before the timeout error (>= 2)
//   CNT_W      : RUN counter width, 2**CNT_W > MAX_CYCLES
//
// Ports:
//   i_clock      : system clock, rising edge
//   i_reset      : asynchronous reset, active low
//   i_start      : operation request, sampled only while o_busy = 0
//   i_op[1:0]    : [0] 0 = mult, 1 = div
//                  [1] 0 = operands A/B, 1 = MemDataReg/DivMultTempReg
//   i_abort      : synchronous cancel, honoured in LOAD and RUN only
//   i_mult_done  : Mult unit finished
//   i_div_status : 00 running, 01 done, 10 div-by-zero, 11 invalid
//   o_mult_ctrl  : Mult control, 00 hold / 01 load / 10 run / 11 clear
//   o_div_ctrl   : Div control, same encoding
//   o_entry_sel  : DivMultEntry mux select (latched op[1] in LOAD/RUN)
//   o_result_sel : DivorMult select, 0 = Div outputs, 1 = Mult outputs
//   o_write_hi   : Hi register write enable
//   o_write_lo   : Lo register write enable
//   o_busy       : operation in progress
//   o_done       : one-cycle pulse, Hi/Lo hold the valid result
//   o_err        : one-cycle pulse, operation failed, Hi/Lo unchanged
//   o_err_code   : with o_err, 01 div-by-zero/invalid, 10 timeout
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic       i_abort,
    input  logic       i_mult_done,
    input  logic [1:0] i_div_status,
    output logic [1:0] o_mult_ctrl,
    output logic [1:0] o_div_ctrl,
    output logic       o_entry_sel,
    output logic       o_result_sel,
    output logic       o_write_hi,
    output logic       o_write_lo,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5,
        ST_ABORT = 3'd6
    } state_t;

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_LOAD  = 2'b01;
    localparam logic [1:0] CTRL_RUN   = 2'b10;
    localparam logic [1:0] CTRL_CLEAR = 2'b11;

    localparam logic [1:0] ERRC_DIV     = 2'b01;
    localparam logic [1:0] ERRC_TIMEOUT = 2'b10;

    // The counter is cleared in LOAD, so it reads 0 in the first RUN cycle.
    // Reaching MAX_CYCLES-1 therefore means this is RUN cycle MAX_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    state_t           w_state_next;
    logic [1:0]       w_op_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_err_code_next;

    logic w_is_div;
    logic w_completion;
    logic w_div_fault;
    logic w_timeout;

    // -------------------------------------------------------------------------
    // Next-cycle output values. They are decoded from the next state so that
    // the output registers always describe the state being entered.
    // -------------------------------------------------------------------------
    logic [1:0] w_unit_ctrl_next;
    logic [1:0] w_ctrl_next [0:1];   // index 0 = Mult, 1 = Div
    logic       w_entry_sel_next;
    logic       w_result_sel_next;
    logic       w_write_next;
    logic       w_busy_next;
    logic       w_done_next;
    logic       w_err_next;
    logic [1:0] w_err_out_next;

    // -------------------------------------------------------------------------
    // Exit conditions, evaluated against the latched op
    // -------------------------------------------------------------------------
    assign w_is_div = r_op[0];

    // Each unit listens only to its own status line.
    assign w_completion = w_is_div ? (i_div_status == 2'b01) : i_mult_done;

    // Status 10 (div-by-zero) and 11 (invalid) both report as a div error.
    assign w_div_fault = w_is_div & i_div_status[1];

    assign w_timeout = (r_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_cnt_next      = r_cnt;
        w_err_code_next = 2'b00;

        case (r_state)
            // DONE and ERR are not busy, so a new request is accepted there
            // directly, without passing through IDLE.
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    w_state_next = ST_LOAD;
                    w_op_next    = i_op;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_LOAD: begin
                w_cnt_next   = '0;
                w_state_next = i_abort ? ST_ABORT : ST_RUN;
            end

            // The order of these tests sets the exit priority:
            // abort, then completion, then div fault, then timeout.
            ST_RUN: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (i_abort) begin
                    w_state_next = ST_ABORT;
                end else if (w_completion) begin
                    w_state_next = ST_WRITE;
                end else if (w_div_fault) begin
                    w_state_next    = ST_ERR;
                    w_err_code_next = ERRC_DIV;
                end else if (w_timeout) begin
                    w_state_next    = ST_ERR;
                    w_err_code_next = ERRC_TIMEOUT;
                end
            end

            ST_WRITE: w_state_next = ST_DONE;
            ST_ABORT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode of the state being entered
    // -------------------------------------------------------------------------
    always_comb begin
        w_unit_ctrl_next  = CTRL_HOLD;
        w_entry_sel_next  = 1'b0;
        w_result_sel_next = 1'b0;
        w_write_next      = 1'b0;
        w_busy_next       = 1'b0;
        w_done_next       = 1'b0;
        w_err_next        = 1'b0;
        w_err_out_next    = 2'b00;

        case (w_state_next)
            ST_LOAD: begin
                w_unit_ctrl_next = CTRL_LOAD;
                w_busy_next      = 1'b1;
                w_entry_sel_next = w_op_next[1];
            end

            ST_RUN: begin
                w_unit_ctrl_next = CTRL_RUN;
                w_busy_next      = 1'b1;
                w_entry_sel_next = w_op_next[1];
            end

            ST_WRITE: begin
                w_busy_next       = 1'b1;
                w_write_next      = 1'b1;
                w_result_sel_next = ~w_op_next[0];
            end

            // result_sel stays on the finished unit for the done cycle, so
            // anything sampling the unit outputs with done sees a stable mux.
            ST_DONE: begin
                w_done_next       = 1'b1;
                w_result_sel_next = ~w_op_next[0];
            end

            ST_ERR: begin
                w_unit_ctrl_next = CTRL_CLEAR;
                w_err_next       = 1'b1;
                w_err_out_next   = w_err_code_next;
            end

            ST_ABORT: begin
                w_unit_ctrl_next = CTRL_CLEAR;
                w_busy_next      = 1'b1;
            end

            default: ;
        endcase
    end

    // Only the unit picked by op[0] gets the control code; the other holds.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unit_ctrl
            assign w_ctrl_next[gi] = (int'(w_op_next[0]) == gi) ?
                                     w_unit_ctrl_next : CTRL_HOLD;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_op         <= 2'b00;
            r_cnt        <= '0;
            o_mult_ctrl  <= CTRL_HOLD;
            o_div_ctrl   <= CTRL_HOLD;
            o_entry_sel  <= 1'b0;
            o_result_sel <= 1'b0;
            o_write_hi   <= 1'b0;
            o_write_lo   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_op         <= w_op_next;
            r_cnt        <= w_cnt_next;
            o_mult_ctrl  <= w_ctrl_next[0];
            o_div_ctrl   <= w_ctrl_next[1];
            o_entry_sel  <= w_entry_sel_next;
            o_result_sel <= w_result_sel_next;
            o_write_hi   <= w_write_next;
            o_write_lo   <= w_write_next;
            o_busy       <= w_busy_next;
            o_done       <= w_done_next;
            o_err        <= w_err_next;
            o_err_code   <= w_err_out_next;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Purpose:
//   Self-checking bench for muldiv_sequencer.
//   - Directed scenarios pin the model with hand-computed literal values.
//   - Randomised transactions are checked every cycle against a reference
//     model. For each transaction the model plans:
//       * the op,
//       * the abort point,
//       * the completion point,
//       * the div-fault point.
//     It then derives the outcome and the RUN length from the exit
//     priorities, and the expected output vector of every cycle.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int MAXC = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic       abort = 1'b0;
    logic       mult_done = 1'b0;
    logic [1:0] div_status = 2'b00;

    logic [1:0] mult_ctrl, div_ctrl, err_code;
    logic       entry_sel, result_sel, write_hi, write_lo, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] log_v [0:127];
    int          log_n;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .MAX_CYCLES (MAXC),
        .CNT_W      (7)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_op         (op),
        .i_abort      (abort),
        .i_mult_done  (mult_done),
        .i_div_status (div_status),
        .o_mult_ctrl  (mult_ctrl),
        .o_div_ctrl   (div_ctrl),
        .o_entry_sel  (entry_sel),
        .o_result_sel (result_sel),
        .o_write_hi   (write_hi),
        .o_write_lo   (write_lo),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_err_code   (err_code)
    );

    typedef enum int {S_IDLE, S_LOAD, S_RUN, S_WRITE, S_DONE, S_ERR, S_ABORT} ph_t;

    // Output vector layout:
    //   [12:11] mult_ctrl   [10:9] div_ctrl   [8] entry_sel   [7] result_sel
    //   [6] write_hi        [5] write_lo      [4] busy        [3] done
    //   [2] err             [1:0] err_code
    function automatic logic [12:0] dut_vec();
        return {mult_ctrl, div_ctrl, entry_sel, result_sel, write_hi, write_lo,
                busy, done, err, err_code};
    endfunction

    // Expected outputs of one phase, from the per-state output table
    function automatic logic [12:0] exp_vec(input ph_t ph, input logic [1:0] o,
                                            input logic [1:0] code);
        logic [1:0] uc = 2'b00;
        logic es = 1'b0, rs = 1'b0, wr = 1'b0, bz = 1'b0, dn = 1'b0, er = 1'b0;
        logic [1:0] ec = 2'b00;
        logic [1:0] mc, dc;
        case (ph)
            S_LOAD:  begin uc = 2'b01; bz = 1'b1; es = o[1]; end
            S_RUN:   begin uc = 2'b10; bz = 1'b1; es = o[1]; end
            S_WRITE: begin bz = 1'b1; wr = 1'b1; rs = ~o[0]; end
            S_DONE:  begin dn = 1'b1; rs = ~o[0]; end
            S_ERR:   begin uc = 2'b11; er = 1'b1; ec = code; end
            S_ABORT: begin uc = 2'b11; bz = 1'b1; end
            default: ;
        endcase
        mc = o[0] ? 2'b00 : uc;
        dc = o[0] ? uc : 2'b00;
        return {mc, dc, es, rs, wr, wr, bz, dn, er, ec};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] rds();
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, then compare the outputs of the next cycle.
    task automatic cyc(input logic s, input logic [1:0] o, input logic ab,
                       input logic md, input logic [1:0] ds,
                       input logic [12:0] ev, input string nm);
        start = s; op = o; abort = ab; mult_done = md; div_status = ds;
        @(posedge clk); #1;
        check(nm, 32'(dut_vec()), 32'(ev));
    endtask

    // Directed scenario: start from a not-busy state and log every output
    // vector until done, err or the return to idle.
    // RUN cycle r lies at log index t = r + 1; index 1 is LOAD.
    // k     : RUN cycle of the completion or fault signal, -1 for never
    // ab_at : RUN cycle of the abort, -1 for none
    task automatic scen(input logic [1:0] o, input int k, input logic [1:0] ds_k,
                        input int ab_at);
        start = 1'b1; op = o; abort = 1'b0; mult_done = 1'b0; div_status = 2'b00;
        log_n = 0;
        for (int t = 1; t <= 100; t++) begin
            @(posedge clk); #1;
            log_v[t] = dut_vec();
            log_n = t;
            start = 1'b0;
            mult_done  = (o[0] == 1'b0) && (t - 1 == k);
            div_status = (o[0] == 1'b1 && t - 1 == k) ? ds_k : 2'b00;
            abort      = (t - 1 == ab_at);
            if (done || err || !busy) break;
        end
        abort = 1'b0; mult_done = 1'b0; div_status = 2'b00;
    endtask

    // One randomised transaction; the DUT must not be busy when it is called.
    task automatic run_txn(input int idx);
        logic [1:0] o;
        logic       ab_load;
        int         a, b, c, mode, n_end;
        ph_t        kind;
        logic [1:0] code;

        o       = rds();
        ab_load = ($urandom_range(0, 15) == 0);
        a       = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 70)) : 0;
        mode    = $urandom_range(0, 9);
        c       = (mode < 7) ? int'($urandom_range(1, 12)) :
                  (mode == 7) ? int'($urandom_range(1, 70)) : 0;
        b       = (o[0] && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;

        // Outcome: the earliest event ends RUN. Events are applied from lowest
        // to highest priority with <=, so a higher-priority event wins a tie.
        n_end = MAXC; kind = S_ERR; code = 2'b10;
        if (b != 0 && b <= n_end) begin n_end = b; kind = S_ERR;   code = 2'b01; end
        if (c != 0 && c <= n_end) begin n_end = c; kind = S_WRITE; code = 2'b00; end
        if (a != 0 && a <= n_end) begin n_end = a; kind = S_ABORT; code = 2'b00; end
        if (ab_load) begin n_end = 0; kind = S_ABORT; code = 2'b00; end

        $display("txn %0d: op=%b abort_load=%0b a=%0d c=%0d b=%0d -> %s after %0d RUN cycles",
                 idx, o, ab_load, a, c, b, kind.name(), n_end);

        // Request cycle, then the LOAD cycle (inputs other than abort are noise)
        cyc(1'b1, o, rb(), rb(), rds(), exp_vec(S_LOAD, o, 2'b00), "txn_load");
        cyc(rb(), rds(), ab_load, rb(), rds(),
            ab_load ? exp_vec(S_ABORT, o, 2'b00) : exp_vec(S_RUN, o, 2'b00), "txn_load_exit");

        for (int j = 1; j <= n_end; j++) begin
            logic       md;
            logic [1:0] ds;
            md = o[0] ? rb() : logic'(j == c);
            if (o[0])
                ds = (j == c) ? 2'b01 : ((j == b) ? {1'b1, rb()} : 2'b00);
            else
                ds = rds();
            cyc(rb(), rds(), logic'(j == a), md, ds,
                (j < n_end) ? exp_vec(S_RUN, o, 2'b00) : exp_vec(kind, o, code), "txn_run");
        end

        if (kind == S_ABORT)
            cyc(rb(), rds(), rb(), rb(), rds(), exp_vec(S_IDLE, o, 2'b00), "txn_abort_idle");
        else if (kind == S_WRITE)
            cyc(rb(), rds(), rb(), rb(), rds(), exp_vec(S_DONE, o, 2'b00), "txn_done");

        // Optional idle gap; with no gap the next request lands in DONE/ERR/IDLE.
        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
            cyc(1'b0, rds(), rb(), rb(), rds(), exp_vec(S_IDLE, 2'b00, 2'b00), "txn_gap_idle");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         cnt;
        logic [1:0] seq1 [0:4];
        seq1[0] = 2'b01; seq1[1] = 2'b10; seq1[2] = 2'b10; seq1[3] = 2'b10; seq1[4] = 2'b00;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        #1 check("reset_async_zero", 32'(dut_vec()), 32'd0);
        @(posedge clk); #1;
        check("reset_held_zero", 32'(dut_vec()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", 32'(dut_vec()), 32'd0);

        // ---------------- 1: mult, done in RUN cycle 3 ----------------
        scen(2'b00, 3, 2'b00, -1);
        check("t1_start_to_done", 32'(log_n), 32'd6);
        for (int t = 1; t <= 5; t++)
            check("t1_mult_ctrl_seq", 32'(log_v[t][12:11]), 32'(seq1[t - 1]));
        cnt = 0;
        for (int t = 1; t <= log_n; t++) cnt += int'(log_v[t][6]);
        check("t1_write_cycles", 32'(cnt), 32'd1);
        check("t1_write_at_5", 32'(log_v[5][6:5]), 32'b11);
        check("t1_result_sel_done", 32'(log_v[6][7]), 32'd1);
        check("t1_done", 32'(log_v[6][3]), 32'd1);

        // ---------------- 6c: start in the DONE cycle ----------------
        start = 1'b1; op = 2'b01;
        @(posedge clk); #1;
        check("t6_start_in_done_divctrl", 32'(div_ctrl), 32'b01);
        check("t6_start_in_done_busy", 32'(busy), 32'd1);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, exp_vec(S_ABORT, 2'b01, 2'b00), "t6_load_abort");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 13'd0, "t6_abort_to_idle");

        // ---------------- 2: div from memory, done after 5 RUN cycles ----------------
        scen(2'b11, 5, 2'b01, -1);
        check("t2_start_to_done", 32'(log_n), 32'd8);
        cnt = 0;
        for (int t = 1; t <= 6; t++) cnt += int'(log_v[t][8]);
        check("t2_entry_sel_load_run", 32'(cnt), 32'd6);
        check("t2_div_load", 32'(log_v[1][10:9]), 32'b01);
        check("t2_result_sel", 32'(log_v[8][7]), 32'd0);
        check("t2_done", 32'(log_v[8][3]), 32'd1);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 13'd0, "t2_idle");

        // ---------------- 3: div-by-zero in RUN cycle 2 ----------------
        scen(2'b01, 2, 2'b10, -1);
        check("t3_len", 32'(log_n), 32'd4);
        check("t3_err", 32'(log_v[4][2]), 32'd1);
        check("t3_err_code", 32'(log_v[4][1:0]), 32'b01);
        check("t3_div_clear", 32'(log_v[4][10:9]), 32'b11);
        check("t3_busy_low", 32'(log_v[4][4]), 32'd0);
        cnt = 0;
        for (int t = 1; t <= log_n; t++) cnt += int'(log_v[t][6]) + int'(log_v[t][5]);
        check("t3_no_write", 32'(cnt), 32'd0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 13'd0, "t3_idle");

        // ---------------- 4: mult timeout ----------------
        scen(2'b00, -1, 2'b00, -1);
        check("t4_len", 32'(log_n), 32'd66);
        cnt = 0;
        for (int t = 1; t <= log_n; t++) cnt += int'(log_v[t][12:11] == 2'b10);
        check("t4_run_cycles", 32'(cnt), 32'd64);
        check("t4_err", 32'(log_v[66][2]), 32'd1);
        check("t4_err_code", 32'(log_v[66][1:0]), 32'b10);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 13'd0, "t4_idle");

        // ---------------- 5: abort in RUN cycle 2 ----------------
        scen(2'b00, -1, 2'b00, 2);
        check("t5_len", 32'(log_n), 32'd5);
        check("t5_clear", 32'(log_v[4][12:11]), 32'b11);
        check("t5_abort_busy", 32'(log_v[4][4]), 32'd1);
        check("t5_idle", 32'(log_v[5]), 32'd0);
        cnt = 0;
        for (int t = 1; t <= log_n; t++) cnt += int'(log_v[t][3]) + int'(log_v[t][2]);
        check("t5_no_done_err", 32'(cnt), 32'd0);

        // ---------------- 6b: start while busy is ignored ----------------
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, exp_vec(S_LOAD, 2'b00, 2'b00), "t6b_load");
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 2'b01, exp_vec(S_RUN, 2'b00, 2'b00), "t6b_run1");
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 2'b01, exp_vec(S_RUN, 2'b00, 2'b00), "t6b_run2");
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 2'b00, exp_vec(S_WRITE, 2'b00, 2'b00), "t6b_write");
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, exp_vec(S_DONE, 2'b00, 2'b00), "t6b_done");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 13'd0, "t6b_idle");

        // ---------------- 6a: reset mid-RUN ----------------
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, exp_vec(S_LOAD, 2'b01, 2'b00), "t6a_load");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, exp_vec(S_RUN, 2'b01, 2'b00), "t6a_run");
        #2 rst_n = 1'b0;
        #1 check("t6a_reset_midrun", 32'(dut_vec()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6a_idle_after_reset", 32'(dut_vec()), 32'd0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 13'd0, "t6a_no_pulse");

        // ---------------- randomised transactions ----------------
        for (int i = 0; i < 150; i++) run_txn(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
